mul_arbiter: RTL and testbench

Sequencing and sharing controller for the team's 8x8 multiplier datapath. Two requesters (e.g. two ALU issue lanes) compete for one multiplier. The block arbitrates between them, captures the winner's operands, and runs the product through a configurable-latency stage counter. It then returns the truncated 8-bit result plus zero/carry status to the granted requester with a one-cycle done pulse.

---
 rtl/mul_arbiter.sv | 154 +++++++++++++++
 tb/tb_mul_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of one shared 8x8 multiplier with a MUL_STAGES-cycle stage counter.
// Define MUL_ARB_RR_EN for round-robin tie-breaking; the default build gives requester 0 fixed priority.
module mul_arbiter #(
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] op1_0,
  input  logic [7:0] op2_0,
  input  logic       req1,
  input  logic [7:0] op1_1,
  input  logic [7:0] op2_1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic [3:0] status,
  output logic       busy,
  output logic       owner
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_STAGES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       opa, opb, opa_next, opb_next;
  logic [7:0]       result_next;
  logic [3:0]       status_next;
  logic             ack0_next, ack1_next, done0_next, done1_next;
  logic             busy_next, owner_next;
  logic             req_any, winner, grant;
  logic [15:0]      product;

  assign req_any = req0 | req1;
  assign product = 16'(opa) * 16'(opb);

`ifdef MUL_ARB_RR_EN
  // rr_ptr holds the last served requester; a tie goes to the other one
  logic rr_ptr;

  assign winner = (req0 & req1) ? ~rr_ptr : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= 1'b1;
    else if (grant)
      rr_ptr <= winner;
  end
`else
  assign winner = ~req0 & req1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state: arbitration happens in IDLE and DONE only
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          grant      = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt == '0)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        if (req_any) begin
          grant      = 1'b1;
          state_next = ST_BUSY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ack0_next   = 1'b0;
    ack1_next   = 1'b0;
    done0_next  = 1'b0;
    done1_next  = 1'b0;
    cnt_next    = cnt;
    opa_next    = opa;
    opb_next    = opb;
    owner_next  = owner;
    result_next = result;
    status_next = status;
    busy_next   = (state_next != ST_IDLE);
    if (grant) begin
      opa_next   = winner ? op1_1 : op1_0;
      opb_next   = winner ? op2_1 : op2_0;
      owner_next = winner;
      cnt_next   = CNT_LOAD;
      ack0_next  = ~winner;
      ack1_next  = winner;
    end else if (state == ST_BUSY) begin
      if (cnt != '0) begin
        cnt_next = cnt - CNT_W'(1);
      end else begin
        result_next = product[7:0];
        status_next = {|product[15:8], ~|product[7:0], 2'b00};
        done0_next  = ~owner;
        done1_next  = owner;
      end
    end
  end

  // Registered outputs and operand/counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= '0;
      status <= '0;
      busy   <= 1'b0;
      owner  <= 1'b0;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
    end else begin
      ack0   <= ack0_next;
      ack1   <= ack1_next;
      done0  <= done0_next;
      done1  <= done1_next;
      result <= result_next;
      status <= status_next;
      busy   <= busy_next;
      owner  <= owner_next;
      cnt    <= cnt_next;
      opa    <= opa_next;
      opb    <= opb_next;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: vector table, grant sequences, DONE-cycle re-arbitration, reset abort.
module tb_mul_arbiter;

  localparam int unsigned MS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] op1_0 = '0, op2_0 = '0, op1_1 = '0, op2_1 = '0;
  logic       ack0, ack1, done0, done1, busy, owner;
  logic [7:0] result;
  logic [3:0] status;

  mul_arbiter #(.MUL_STAGES(MS)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op1_0(op1_0), .op2_0(op2_0),
    .req1(req1), .op1_1(op1_1), .op2_1(op2_1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .result(result), .status(status), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       who;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    logic       who;
    logic [7:0] res;
    logic [3:0] st;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   dones = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic who, input logic [7:0] a, input logic [7:0] b);
    exp_t        e;
    logic [15:0] p;
    p     = 16'(a) * 16'(b);
    e.who = who;
    e.res = p[7:0];
    e.st  = {|p[15:8], ~|p[7:0], 2'b00};
    return e;
  endfunction

  // One cycle: wait for the falling edge, then score any done pulse against the queue
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (done0 || done1) begin
      dones++;
      check("single_done", 32'(done0 & done1), 32'(0));
      check("ack_done_overlap", 32'(done0 ? ack0 : ack1), 32'(0));
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done actual=done required=no_done");
      end else begin
        e = sbq.pop_front();
        check("done_who", 32'(done1), 32'(e.who));
        check("result", 32'(result), 32'(e.res));
        check("status", 32'(status), 32'(e.st));
      end
    end
  endtask

  task automatic raise(input logic who, input logic [7:0] a, input logic [7:0] b);
    if (who) begin
      op1_1 = a; op2_1 = b; req1 = 1'b1;
    end else begin
      op1_0 = a; op2_0 = b; req0 = 1'b1;
    end
  endtask

  task automatic drop(input logic who);
    if (who) req1 = 1'b0;
    else     req0 = 1'b0;
  endtask

  task automatic wait_ack(input logic who, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(who ? ack1 : ack0) && n < 20);
  endtask

  task automatic wait_done(input logic who, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(who ? done1 : done0) && n < 20);
  endtask

  // Single operation from IDLE, with latency, owner and post-DONE idle checks
  task automatic do_op(input logic who, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic [3:0] st);
    int   n;
    exp_t e;
    raise(who, a, b);
    e.who = who; e.res = res; e.st = st;
    sbq.push_back(e);
    wait_ack(who, n);
    check("ack_latency", 32'(n), 32'(1));
    check("owner", 32'(owner), 32'(who));
    drop(who);
    wait_done(who, n);
    check("done_latency", 32'(n), 32'(MS));
    tick();
    check("busy_after_done", 32'(busy), 32'(0));
  endtask

  initial begin
    vec_t tbl[7];
    logic grants[4];
    logic exp_g[4];
    int   n, ngr, last, d0;
    exp_t e;

    tbl[0] = '{1'b0, 8'h0C, 8'h0A, 8'h78, 4'b0000};
    tbl[1] = '{1'b1, 8'h10, 8'h10, 8'h00, 4'b1100};
    tbl[2] = '{1'b1, 8'hFF, 8'h02, 8'hFE, 4'b1000};
    tbl[3] = '{1'b0, 8'h00, 8'hFF, 8'h00, 4'b0100};
    tbl[4] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 4'b1000};
    tbl[5] = '{1'b0, 8'h10, 8'h20, 8'h00, 4'b1100};
    tbl[6] = '{1'b1, 8'h01, 8'h01, 8'h01, 4'b0000};

`ifdef MUL_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_result", 32'(result), 32'(0));
    check("rst_status", 32'(status), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    check("rst_pulses", 32'({ack0, ack1, done0, done1}), 32'(0));

    for (int i = 0; i < 7; i++)
      do_op(tbl[i].who, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].st);

    // Both requesters held high: grant order and back-to-back spacing
    raise(1'b0, 8'h03, 8'h04);
    raise(1'b1, 8'h05, 8'h06);
    ngr = 0; n = 0; last = 0;
    while (ngr < 4 && n < 60) begin
      tick();
      n++;
      if (ngr > 0) check("no_idle_gap", 32'(busy), 32'(1));
      if (ack0 || ack1) begin
        grants[ngr] = ack1;
        if (ngr > 0) check("grant_spacing", 32'(n - last), 32'(MS + 1));
        last = n;
        sbq.push_back(ack1 ? model(1'b1, 8'h05, 8'h06) : model(1'b0, 8'h03, 8'h04));
        ngr++;
      end
    end
    drop(1'b0);
    drop(1'b1);
    check("grant_count", 32'(ngr), 32'(4));
    for (int i = 0; i < 4; i++)
      if (i < ngr) check("grant_order", 32'(grants[i]), 32'(exp_g[i]));
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain", 32'(sbq.size()), 32'(0));
    tick();
    check("busy_idle_after_stream", 32'(busy), 32'(0));

    // req1 raised during the DONE cycle of a req0 operation
    raise(1'b0, 8'h02, 8'h03);
    sbq.push_back(model(1'b0, 8'h02, 8'h03));
    wait_ack(1'b0, n);
    check("ack0_latency_b2b", 32'(n), 32'(1));
    drop(1'b0);
    wait_done(1'b0, n);
    check("done0_latency_b2b", 32'(n), 32'(MS));
    raise(1'b1, 8'h07, 8'h09);
    sbq.push_back(model(1'b1, 8'h07, 8'h09));
    tick();
    check("ack1_from_done", 32'(ack1), 32'(1));
    check("busy_from_done", 32'(busy), 32'(1));
    check("owner_from_done", 32'(owner), 32'(1));
    drop(1'b1);
    wait_done(1'b1, n);
    check("done1_latency_b2b", 32'(n), 32'(MS));
    tick();

    // Reset in the middle of BUSY discards the operation
    raise(1'b0, 8'h11, 8'h11);
    wait_ack(1'b0, n);
    check("ack_before_rst", 32'(n), 32'(1));
    drop(1'b0);
    rst = 1'b1;
    #1;
    check("midrst_result", 32'(result), 32'(0));
    check("midrst_status", 32'(status), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_owner", 32'(owner), 32'(0));
    tick();
    rst = 1'b0;
    d0 = dones;
    repeat (5) tick();
    check("no_done_after_rst", 32'(dones), 32'(d0));
    do_op(1'b0, 8'h03, 8'h05, 8'h0F, 4'b0000);

    check("sb_final_empty", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
